hash_ingest: RTL and testbench

- Upstream feeder for the reordering engine.
- Accepts a stream of 32-bit words over a valid/ready interface and assembles each group of words into one 256-bit perceptual hash.
- Writes each assembled hash into the hash memory at a sequential index, then counts the images in the frame.
- When the frame ends, pulses start with num_images to launch reordering, and holds off new input until reordering has finished.

---
 rtl/hash_ingest.sv | 222 ++++++++++++++++++++++
 tb/tb_hash_ingest.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_ingest.sv
// hash_ingest: packs WORD_W stream beats into HASH_W hashes, writes them to the hash memory
// and launches reordering at frame end. Optional checksum word: HASH_INGEST_CHECKSUM_EN.
module hash_ingest #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned HASH_W     = 256,
    parameter int unsigned IDX_W      = 16,
    parameter int unsigned MAX_IMAGES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [HASH_W-1:0] mem_wdata,
    output logic [IDX_W-1:0]  num_images,
    output logic              start,
    input  logic              busy,
    output logic              err_short,
`ifdef HASH_INGEST_CHECKSUM_EN
    output logic              err_checksum,
`endif
    output logic              err_overflow
);

    localparam int unsigned BEATS  = HASH_W / WORD_W;
`ifdef HASH_INGEST_CHECKSUM_EN
    localparam int unsigned NBEATS = BEATS + 1;
`else
    localparam int unsigned NBEATS = BEATS;
`endif
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              done_q, done_d;
    logic              first_q, first_d;
    logic              seen_q, seen_d;

    logic              s_ready_d, mem_we_d, start_d;
    logic [IDX_W-1:0]  mem_addr_d, num_images_d;
    logic [HASH_W-1:0] mem_wdata_d;
    logic              err_short_d, err_overflow_d;
`ifdef HASH_INGEST_CHECKSUM_EN
    logic [WORD_W-1:0] xor_q, xor_d;
    logic              err_checksum_d;
`endif

    logic              accept;
    logic              last_beat;
    logic [HASH_W-1:0] hash_c;

    assign accept    = s_valid && s_ready;
    assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

    // Current hash with the incoming word merged in at its beat slot (beat 0 = LSBs)
    always_comb begin
        hash_c = hash_q;
        for (int k = 0; k < int'(BEATS); k++) begin
            if (beat_q == BEAT_W'(k)) begin
                hash_c[k*WORD_W +: WORD_W] = s_data;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        count_d        = count_q;
        hash_d         = hash_q;
        done_d         = 1'b0;
        first_d        = first_q;
        seen_d         = seen_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        start_d        = 1'b0;
        num_images_d   = num_images;
        err_short_d    = err_short;
        err_overflow_d = err_overflow;
`ifdef HASH_INGEST_CHECKSUM_EN
        xor_d          = xor_q;
        err_checksum_d = err_checksum;
`endif

        case (state_q)
            FILL: begin
                if (done_q) begin
                    // final hash was written last cycle
                    state_d = LAUNCH;
                end else if (accept) begin
                    if (first_q) begin
                        err_short_d    = 1'b0;
                        err_overflow_d = 1'b0;
`ifdef HASH_INGEST_CHECKSUM_EN
                        err_checksum_d = 1'b0;
`endif
                    end
                    first_d = 1'b0;
                    hash_d  = hash_c;
`ifdef HASH_INGEST_CHECKSUM_EN
                    xor_d   = (beat_q == '0) ? s_data : (xor_q ^ s_data);
`endif
                    if (last_beat) begin
                        beat_d = '0;
`ifdef HASH_INGEST_CHECKSUM_EN
                        if (s_data != xor_q) begin
                            err_checksum_d = 1'b1;
                        end else
`endif
                        if (count_q == IDX_W'(MAX_IMAGES)) begin
                            err_overflow_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = count_q;
                            mem_wdata_d = hash_c;
                            count_d     = count_q + IDX_W'(1);
                        end
                        if (s_last) begin
                            if (count_d != '0) begin
                                done_d = 1'b1;
                            end else begin
                                first_d = 1'b1;
                            end
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (s_last) begin
                            // partial hash is dropped
                            beat_d      = '0;
                            err_short_d = 1'b1;
                            if (count_q != '0) begin
                                state_d = LAUNCH;
                            end else begin
                                first_d = 1'b1;
                            end
                        end
                    end
                end
            end
            LAUNCH: begin
                state_d = HOLD;
                seen_d  = 1'b0;
            end
            HOLD: begin
                if (busy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    state_d = FILL;
                    count_d = '0;
                    beat_d  = '0;
                    seen_d  = 1'b0;
                    first_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (state_d == LAUNCH) begin
            start_d      = 1'b1;
            num_images_d = count_d;
        end
        s_ready_d = (state_d == FILL) && !done_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            beat_q       <= '0;
            count_q      <= '0;
            hash_q       <= '0;
            done_q       <= 1'b0;
            first_q      <= 1'b1;
            seen_q       <= 1'b0;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            start        <= 1'b0;
            num_images   <= '0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
`ifdef HASH_INGEST_CHECKSUM_EN
            xor_q        <= '0;
            err_checksum <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            count_q      <= count_d;
            hash_q       <= hash_d;
            done_q       <= done_d;
            first_q      <= first_d;
            seen_q       <= seen_d;
            s_ready      <= s_ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            start        <= start_d;
            num_images   <= num_images_d;
            err_short    <= err_short_d;
            err_overflow <= err_overflow_d;
`ifdef HASH_INGEST_CHECKSUM_EN
            xor_q        <= xor_d;
            err_checksum <= err_checksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_hash_ingest.sv
// tb_hash_ingest: directed checks of hash_ingest frame assembly, short and overflow frames,
// the launch/hold handshake and reset while holding.
`timescale 1ns/1ps
module tb_hash_ingest;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HASH_W = 256;
    localparam int unsigned IDX_W  = 16;
    localparam int unsigned BEATS  = HASH_W / WORD_W;
`ifdef HASH_INGEST_CHECKSUM_EN
    localparam int WPH = BEATS + 1;
`else
    localparam int WPH = BEATS;
`endif

    logic              clk = 1'b0;
    logic              reset, s_valid, s_last, busy, sel;
    logic [WORD_W-1:0] s_data;
    logic              v1, v2, rdy_sel, start_sel;

    logic              rdy1, we1, start1, eshort1, eovf1;
    logic [IDX_W-1:0]  addr1, num1;
    logic [HASH_W-1:0] wdata1;
    logic              rdy2, we2, start2, eshort2, eovf2;
    logic [IDX_W-1:0]  addr2, num2;
    logic [HASH_W-1:0] wdata2;
`ifdef HASH_INGEST_CHECKSUM_EN
    logic              echk1, echk2;
`endif

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;
    bit gappy = 1'b0;

    logic [IDX_W-1:0]  wa1[$];
    logic [HASH_W-1:0] wd1[$];
    int                wc1[$];
    int                nstart1 = 0;
    int                sc1 = 0;
    logic [IDX_W-1:0]  snum1 = '0;
    logic [IDX_W-1:0]  wa2[$];
    logic [HASH_W-1:0] wd2[$];
    int                nstart2 = 0;

    assign v1        = s_valid & ~sel;
    assign v2        = s_valid & sel;
    assign rdy_sel   = sel ? rdy2 : rdy1;
    assign start_sel = sel ? start2 : start1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hash_ingest dut (
        .clk(clk), .reset(reset), .s_valid(v1), .s_ready(rdy1), .s_data(s_data), .s_last(s_last),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .num_images(num1), .start(start1),
        .busy(busy), .err_short(eshort1),
`ifdef HASH_INGEST_CHECKSUM_EN
        .err_checksum(echk1),
`endif
        .err_overflow(eovf1)
    );

    hash_ingest #(.MAX_IMAGES(4)) dut4 (
        .clk(clk), .reset(reset), .s_valid(v2), .s_ready(rdy2), .s_data(s_data), .s_last(s_last),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .num_images(num2), .start(start2),
        .busy(busy), .err_short(eshort2),
`ifdef HASH_INGEST_CHECKSUM_EN
        .err_checksum(echk2),
`endif
        .err_overflow(eovf2)
    );

    // Record memory writes and start pulses away from the active edge
    always @(negedge clk) begin
        if (we1 === 1'b1) begin wa1.push_back(addr1); wd1.push_back(wdata1); wc1.push_back(cyc); end
        if (start1 === 1'b1) begin nstart1++; sc1 = cyc; snum1 = num1; end
        if (we2 === 1'b1) begin wa2.push_back(addr2); wd2.push_back(wdata2); end
        if (start2 === 1'b1) nstart2++;
    end

    task automatic clear_mon();
        wa1.delete(); wd1.delete(); wc1.delete(); nstart1 = 0;
        wa2.delete(); wd2.delete(); nstart2 = 0;
    endtask

    task automatic put(input logic [WORD_W-1:0] d, input logic l);
        int n;
        n = 0;
        if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        while (rdy_sel !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (rdy_sel !== 1'b1) begin vec++; miss++; $display("FAIL put_timeout: s_ready=%b required 1", rdy_sel); end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_hash(input logic [HASH_W-1:0] h, input logic l, input logic bad, input int from_k);
        logic [WORD_W-1:0] x;
        x = '0;
        for (int k = 0; k < int'(BEATS); k++) begin
            x ^= h[k*WORD_W +: WORD_W];
`ifdef HASH_INGEST_CHECKSUM_EN
            if (k >= from_k) put(h[k*WORD_W +: WORD_W], 1'b0);
`else
            if (k >= from_k) put(h[k*WORD_W +: WORD_W], l && (k == int'(BEATS) - 1));
`endif
        end
`ifdef HASH_INGEST_CHECKSUM_EN
        put(bad ? ~x : x, l);
`endif
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (start_sel !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        ok = (start_sel === 1'b1);
    endtask

    task automatic serve_busy(input int dly, input int len, output int bad_ready, output logic rdy_after);
        bad_ready = 0;
        repeat (dly) begin @(negedge clk); if (rdy_sel !== 1'b0) bad_ready++; end
        busy = 1'b1;
        repeat (len) begin @(negedge clk); if (rdy_sel !== 1'b0) bad_ready++; end
        busy = 1'b0;
        @(negedge clk);
        rdy_after = rdy_sel;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; busy = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if (rdy1 !== 1'b0) begin miss++; $display("FAIL reset_ready: got %b want 0", rdy1); end
        vec++; if (we1 !== 1'b0 || start1 !== 1'b0) begin miss++; $display("FAIL reset_strobes: we=%b start=%b want 0 0", we1, start1); end
        vec++; if (addr1 !== '0 || num1 !== '0) begin miss++; $display("FAIL reset_idx: addr=%0d num=%0d want 0 0", addr1, num1); end
        vec++; if (wdata1 !== '0) begin miss++; $display("FAIL reset_wdata: got %h want 0", wdata1); end
        vec++; if (eshort1 !== 1'b0 || eovf1 !== 1'b0) begin miss++; $display("FAIL reset_err: short=%b ovf=%b want 0 0", eshort1, eovf1); end
        reset = 1'b0;
        @(negedge clk);
        vec++; if (rdy1 !== 1'b1) begin miss++; $display("FAIL ready_after_reset: got %b want 1", rdy1); end
    endtask

    task automatic test_five_hashes();
        logic [HASH_W-1:0] h, exp;
        bit ok; int bad; logic ra;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            h = '0; if (i == 0) h[0] = 1'b1;
            send_hash(h, i == 4, 1'b0, 0);
        end
        wait_start(ok);
        vec++; if (!ok) begin miss++; $display("FAIL five_start: start not seen, want pulse"); end
        vec++; if (rdy1 !== 1'b0) begin miss++; $display("FAIL five_ready_launch: got %b want 0", rdy1); end
        vec++; if (num1 !== IDX_W'(5)) begin miss++; $display("FAIL five_num: got %0d want 5", num1); end
        serve_busy(2, 10, bad, ra);
        vec++; if (bad != 0) begin miss++; $display("FAIL five_ready_hold: %0d cycles ready, want 0", bad); end
        vec++; if (ra !== 1'b1) begin miss++; $display("FAIL five_ready_after: got %b want 1", ra); end
        vec++; if (nstart1 != 1) begin miss++; $display("FAIL five_start_len: %0d start cycles want 1", nstart1); end
        vec++; if (wa1.size() != 5) begin miss++; $display("FAIL five_writes: got %0d want 5", wa1.size()); end
        if (wa1.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                exp = '0; if (i == 0) exp[0] = 1'b1;
                vec++; if (wa1[i] !== IDX_W'(i)) begin miss++; $display("FAIL five_addr%0d: got %0d want %0d", i, wa1[i], i); end
                vec++; if (wd1[i] !== exp) begin miss++; $display("FAIL five_data%0d: got %h want %h", i, wd1[i], exp); end
                if (i > 0) begin
                    vec++; if (wc1[i] - wc1[i-1] != WPH) begin miss++; $display("FAIL five_spacing%0d: got %0d want %0d", i, wc1[i] - wc1[i-1], WPH); end
                end
            end
            vec++; if (sc1 != wc1[4] + 1) begin miss++; $display("FAIL five_start_cycle: got %0d want %0d", sc1, wc1[4] + 1); end
        end
        vec++; if (eshort1 !== 1'b0) begin miss++; $display("FAIL five_err_short: got %b want 0", eshort1); end
    endtask

    task automatic test_gappy();
        logic [HASH_W-1:0] h0, h1;
        bit ok; int bad; logic ra;
        for (int k = 0; k < int'(BEATS); k++) begin
            h0[k*WORD_W +: WORD_W] = 32'hA000_0000 | k;
            h1[k*WORD_W +: WORD_W] = 32'hA000_0100 | (k * 3);
        end
        clear_mon();
        gappy = 1'b1;
        send_hash(h0, 1'b0, 1'b0, 0);
        send_hash(h1, 1'b1, 1'b0, 0);
        gappy = 1'b0;
        wait_start(ok);
        vec++; if (!ok || num1 !== IDX_W'(2)) begin miss++; $display("FAIL gappy_start: seen=%0d num=%0d want 1 2", ok, num1); end
        serve_busy(1, 3, bad, ra);
        vec++; if (wa1.size() != 2) begin miss++; $display("FAIL gappy_writes: got %0d want 2", wa1.size()); end
        if (wa1.size() == 2) begin
            vec++; if (wd1[0] !== h0 || wa1[0] !== '0) begin miss++; $display("FAIL gappy_hash0: got %h want %h", wd1[0], h0); end
            vec++; if (wd1[1] !== h1 || wa1[1] !== IDX_W'(1)) begin miss++; $display("FAIL gappy_hash1: got %h want %h", wd1[1], h1); end
        end
        vec++; if (ra !== 1'b1) begin miss++; $display("FAIL gappy_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_short();
        logic [HASH_W-1:0] h;
        bit ok; int bad; logic ra;
        clear_mon();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < int'(BEATS); k++) h[k*WORD_W +: WORD_W] = 32'h5000_0000 | (i << 8) | k;
            send_hash(h, 1'b0, 1'b0, 0);
        end
        put(32'h1111_1111, 1'b0);
        put(32'h2222_2222, 1'b0);
        put(32'h3333_3333, 1'b1);
        wait_start(ok);
        vec++; if (!ok || num1 !== IDX_W'(2)) begin miss++; $display("FAIL short_start: seen=%0d num=%0d want 1 2", ok, num1); end
        vec++; if (eshort1 !== 1'b1) begin miss++; $display("FAIL short_err: got %b want 1", eshort1); end
        serve_busy(3, 4, bad, ra);
        vec++; if (wa1.size() != 2) begin miss++; $display("FAIL short_writes: got %0d want 2", wa1.size()); end
        vec++; if (bad != 0 || ra !== 1'b1) begin miss++; $display("FAIL short_hold: bad=%0d ready_after=%b want 0 1", bad, ra); end
    endtask

    task automatic test_tiny();
        logic [HASH_W-1:0] h;
        bit ok; int bad; logic ra;
        clear_mon();
        put(32'hDEAD_0001, 1'b0);
        put(32'hDEAD_0002, 1'b0);
        put(32'hDEAD_0003, 1'b1);
        repeat (10) @(negedge clk);
        vec++; if (wa1.size() != 0 || nstart1 != 0) begin miss++; $display("FAIL tiny_quiet: writes=%0d starts=%0d want 0 0", wa1.size(), nstart1); end
        vec++; if (eshort1 !== 1'b1 || rdy1 !== 1'b1) begin miss++; $display("FAIL tiny_err: short=%b ready=%b want 1 1", eshort1, rdy1); end
        for (int k = 0; k < int'(BEATS); k++) h[k*WORD_W +: WORD_W] = 32'h7700_0000 | (k << 4);
        put(h[WORD_W-1:0], 1'b0);
        vec++; if (eshort1 !== 1'b0) begin miss++; $display("FAIL tiny_err_clear: got %b want 0", eshort1); end
        send_hash(h, 1'b1, 1'b0, 1);
        wait_start(ok);
        vec++; if (!ok || num1 !== IDX_W'(1)) begin miss++; $display("FAIL single_start: seen=%0d num=%0d want 1 1", ok, num1); end
        serve_busy(4, 2, bad, ra);
        vec++; if (wa1.size() != 1) begin miss++; $display("FAIL single_writes: got %0d want 1", wa1.size()); end
        if (wa1.size() == 1) begin
            vec++; if (wa1[0] !== '0 || wd1[0] !== h) begin miss++; $display("FAIL single_hash: addr=%0d data=%h want 0 %h", wa1[0], wd1[0], h); end
        end
    endtask

    task automatic test_overflow();
        logic [HASH_W-1:0] h, h3;
        bit ok; int bad; logic ra;
        clear_mon();
        sel = 1'b1;
        h3 = '0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < int'(BEATS); k++) h[k*WORD_W +: WORD_W] = 32'hB000_0000 | (i << 8) | k;
            if (i == 3) h3 = h;
            send_hash(h, i == 5, 1'b0, 0);
        end
        wait_start(ok);
        vec++; if (!ok || num2 !== IDX_W'(4)) begin miss++; $display("FAIL ovf_start: seen=%0d num=%0d want 1 4", ok, num2); end
        vec++; if (eovf2 !== 1'b1) begin miss++; $display("FAIL ovf_err: got %b want 1", eovf2); end
        serve_busy(2, 3, bad, ra);
        vec++; if (wa2.size() != 4) begin miss++; $display("FAIL ovf_writes: got %0d want 4", wa2.size()); end
        if (wa2.size() == 4) begin
            vec++; if (wa2[3] !== IDX_W'(3) || wd2[3] !== h3) begin miss++; $display("FAIL ovf_last_write: addr=%0d data=%h want 3 %h", wa2[3], wd2[3], h3); end
        end
        vec++; if (nstart1 != 0) begin miss++; $display("FAIL ovf_isolation: dut starts=%0d want 0", nstart1); end
        sel = 1'b0;
    endtask

    task automatic test_reset_hold();
        logic [HASH_W-1:0] h;
        bit ok;
        clear_mon();
        h = '1;
        send_hash(h, 1'b1, 1'b0, 0);
        wait_start(ok);
        vec++; if (!ok) begin miss++; $display("FAIL rsthold_start: start not seen, want pulse"); end
        @(negedge clk); busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vec++; if (rdy1 !== 1'b0) begin miss++; $display("FAIL rsthold_ready_in_reset: got %b want 0", rdy1); end
        reset = 1'b0;
        @(negedge clk);
        vec++; if (rdy1 !== 1'b1) begin miss++; $display("FAIL rsthold_ready: got %b want 1", rdy1); end
        vec++; if (num1 !== '0 || start1 !== 1'b0) begin miss++; $display("FAIL rsthold_outputs: num=%0d start=%b want 0 0", num1, start1); end
        busy = 1'b0;
    endtask

`ifdef HASH_INGEST_CHECKSUM_EN
    task automatic test_checksum();
        logic [HASH_W-1:0] ha, hb;
        bit ok; int bad; logic ra;
        for (int k = 0; k < int'(BEATS); k++) begin
            ha[k*WORD_W +: WORD_W] = 32'hC000_0000 | k;
            hb[k*WORD_W +: WORD_W] = 32'hC100_0000 | (k << 12);
        end
        clear_mon();
        send_hash(ha, 1'b0, 1'b0, 0);
        send_hash(hb, 1'b1, 1'b1, 0);
        wait_start(ok);
        vec++; if (!ok || num1 !== IDX_W'(1)) begin miss++; $display("FAIL csum_start: seen=%0d num=%0d want 1 1", ok, num1); end
        vec++; if (echk1 !== 1'b1) begin miss++; $display("FAIL csum_err: got %b want 1", echk1); end
        serve_busy(2, 2, bad, ra);
        vec++; if (wa1.size() != 1) begin miss++; $display("FAIL csum_writes: got %0d want 1", wa1.size()); end
        if (wa1.size() == 1) begin
            vec++; if (wd1[0] !== ha) begin miss++; $display("FAIL csum_data: got %h want %h", wd1[0], ha); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_five_hashes();
        test_gappy();
        test_short();
        test_tiny();
        test_overflow();
        test_reset_hold();
`ifdef HASH_INGEST_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
